// File: rtl/dh_modexp_core.sv
// dh_modexp_core: RESULT = BASE^EXP mod MOD, left-to-right square-and-multiply; DH_MODEXP_SKIP_ZERO_EN skips zero exponent bits
module dh_modexp_core #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ST,
  input  logic [WIDTH-1:0] BASE,
  input  logic [WIDTH-1:0] EXP,
  input  logic [WIDTH-1:0] MOD,
  output logic [WIDTH-1:0] RESULT,
  output logic             DONE,
  output logic             BUSY,
  output logic             ERR
);
  localparam int KW = $clog2(WIDTH);
`ifdef DH_MODEXP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, CHECK, PREP, SQR, MUL, FIN} state_t;
  state_t state;
  logic [WIDTH-1:0] base_q, exp_q, mod_q, r, bred, acc, a_op, b_op, mm_out, mul_r;
  logic [WIDTH+1:0] t, t1, m_ext;
  logic [KW-1:0] k, cnt;
  logic ebit, in_mm;
  // acc < MOD and a < MOD, so t < 3*MOD: two conditional subtractions fully reduce it
  always_comb begin
    a_op = state == PREP ? WIDTH'(1) : state == SQR ? r : bred;
    b_op = state == PREP ? base_q : r;
    m_ext = {2'b00, mod_q};
    t = {1'b0, acc, 1'b0} + (b_op[cnt] ? {2'b00, a_op} : '0);
    t1 = t >= m_ext ? t - m_ext : t;
    mm_out = WIDTH'(t1 >= m_ext ? t1 - m_ext : t1);
    ebit = exp_q[k];
    mul_r = ebit ? mm_out : r;
    in_mm = state inside {PREP, SQR, MUL};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      RESULT <= '0;
      DONE <= 1'b0;
      BUSY <= 1'b0;
      ERR <= 1'b0;
      base_q <= '0;
      exp_q <= '0;
      mod_q <= '0;
      r <= '0;
      bred <= '0;
      acc <= '0;
      k <= '0;
      cnt <= '0;
    end else begin
      if (in_mm) begin
        acc <= cnt == 0 ? '0 : mm_out;
        cnt <= cnt == 0 ? KW'(WIDTH - 1) : cnt - 1'b1;
      end
      case (state)
        IDLE: if (ST) begin
          base_q <= BASE;
          exp_q <= EXP;
          mod_q <= MOD;
          k <= KW'(WIDTH - 1);
          BUSY <= 1'b1;
          state <= CHECK;
        end
        CHECK: if (mod_q[WIDTH-1:1] == '0) begin
          RESULT <= '0;
          ERR <= 1'b1;
          DONE <= 1'b1;
          state <= FIN;
        end else if (SKIP && !ebit && k != 0) begin
          k <= k - 1'b1;
        end else begin
          r <= WIDTH'(1);
          acc <= '0;
          cnt <= KW'(WIDTH - 1);
          state <= PREP;
        end
        PREP: if (cnt == 0) begin
          bred <= mm_out;
          state <= SQR;
        end
        SQR: if (cnt == 0) begin
          r <= mm_out;
          if (!(SKIP && !ebit)) state <= MUL;
          else if (k == 0) begin
            RESULT <= mm_out;
            ERR <= 1'b0;
            DONE <= 1'b1;
            state <= FIN;
          end else k <= k - 1'b1;
        end
        MUL: if (cnt == 0) begin
          r <= mul_r;
          if (k == 0) begin
            RESULT <= mul_r;
            ERR <= 1'b0;
            DONE <= 1'b1;
            state <= FIN;
          end else begin
            k <= k - 1'b1;
            state <= SQR;
          end
        end
        FIN: begin
          DONE <= 1'b0;
          BUSY <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dh_modexp_core.sv
// tb_dh_modexp_core: randomized and directed checks of dh_modexp_core against a plain-arithmetic model
module tb_dh_modexp_core;
`ifdef DH_MODEXP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int W = 32;
  localparam int LAT = 2 + W * (2 * W + 1);
  logic CLK = 1'b0, RST = 1'b1, ST = 1'b0;
  logic [W-1:0] BASE = '0, EXP = '0, MOD = '0;
  logic [W-1:0] RESULT;
  logic DONE, BUSY, ERR;
  int checks = 0, errors = 0;
  int cyc = 0, exp_lat = 0, lat_seen = 0;
  bit active = 1'b0, mon_en = 1'b0;
  logic [W-1:0] exp_res = '0, last_res = '0;
  logic exp_err = 1'b0, last_err = 1'b0;
  dh_modexp_core #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .BASE(BASE), .EXP(EXP), .MOD(MOD),
    .RESULT(RESULT), .DONE(DONE), .BUSY(BUSY), .ERR(ERR)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at cycle %0d", name, act, req, cyc);
    end
  endtask
  function automatic logic [W-1:0] model(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
    longint unsigned rr, bb, mm;
    if (m < 2) return '0;
    mm = longint'(m);
    bb = longint'(b) % mm;
    rr = 1;
    for (int i = W - 1; i >= 0; i--) begin
      rr = (rr * rr) % mm;
      if (e[i]) rr = (rr * bb) % mm;
    end
    return rr[W-1:0];
  endfunction
  always @(negedge CLK) begin
    if (mon_en && !RST) begin
      if (active) begin
        cyc++;
        chk("busy_during_op", {31'b0, BUSY}, 1);
        if (DONE) begin
          chk("done_latency_ok", {31'b0, (SKIP && !exp_err) ? cyc <= exp_lat : cyc == exp_lat}, 1);
          chk("result", RESULT, exp_res);
          chk("err", {31'b0, ERR}, {31'b0, exp_err});
          last_res = exp_res;
          last_err = exp_err;
          lat_seen = cyc;
          active = 1'b0;
        end else begin
          chk("result_held_busy", RESULT, last_res);
          chk("err_held_busy", {31'b0, ERR}, {31'b0, last_err});
          if (cyc >= exp_lat) begin
            chk("done_timeout", {31'b0, DONE}, 1);
            active = 1'b0;
          end
        end
      end else begin
        chk("done_idle", {31'b0, DONE}, 0);
        chk("busy_idle", {31'b0, BUSY}, 0);
        chk("result_held_idle", RESULT, last_res);
        chk("err_held_idle", {31'b0, ERR}, {31'b0, last_err});
      end
    end
  end
  task automatic start(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
    @(negedge CLK);
    #1;
    BASE = b;
    EXP = e;
    MOD = m;
    ST = 1'b1;
    exp_res = model(b, e, m);
    exp_err = m < 2;
    exp_lat = m < 2 ? 2 : LAT;
    cyc = 0;
    active = 1'b1;
    @(posedge CLK);
    #1;
    ST = 1'b0;
  endtask
  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m, input bit disturb);
    start(b, e, m);
    if (disturb) begin
      wait (cyc >= 100 || !active);
      #1;
      BASE = $urandom;
      EXP = $urandom;
      MOD = $urandom;
      ST = 1'b1;
      @(posedge CLK);
      #1;
      ST = 1'b0;
      BASE = $urandom;
    end
    wait (!active);
  endtask
  logic [W-1:0] g, p, xa, xb, pa, pb, sa, sb;
  initial begin
    chk("model_17_6_5", model(17, 6, 5), 4);
    chk("model_8_6_5", model(8, 6, 5), 4);
    chk("model_4_6_5", model(4, 6, 5), 1);
    chk("model_3_0_7", model(3, 0, 7), 1);
    chk("model_2_10_1000", model(2, 10, 1000), 24);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_result", RESULT, 0);
    chk("rst_done", {31'b0, DONE}, 0);
    chk("rst_busy", {31'b0, BUSY}, 0);
    chk("rst_err", {31'b0, ERR}, 0);
    mon_en = 1'b1;
    run_op(17, 6, 5, 0);
    if (SKIP) chk("skip_earlier", {31'b0, lat_seen < LAT}, 1);
    run_op(8, 6, 5, 0);
    run_op(4, 6, 5, 0);
    run_op(3, 0, 7, 0);
    run_op(2, 10, 1000, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 0);
    run_op(32'h1234, 32'h55, 1, 0);
    run_op(32'h1234, 32'h55, 0, 0);
    run_op(5, 3, 7, 0);
    run_op(0, 9, 11, 0);
    run_op($urandom, $urandom | 32'h8000_0000, $urandom | 32'h8000_0000, 1);
    start($urandom, 32'hC000_0001, 32'h9000_0007);
    wait (cyc >= 500);
    #1;
    RST = 1'b1;
    active = 1'b0;
    last_res = '0;
    last_err = 1'b0;
    @(posedge CLK);
    #1;
    chk("abort_result", RESULT, 0);
    chk("abort_done", {31'b0, DONE}, 0);
    chk("abort_busy", {31'b0, BUSY}, 0);
    chk("abort_err", {31'b0, ERR}, 0);
    RST = 1'b0;
    run_op(17, 6, 5, 0);
    g = $urandom;
    p = $urandom | 32'h8000_0001;
    xa = $urandom;
    xb = $urandom;
    run_op(g, xa, p, 0);
    pa = last_res;
    run_op(g, xb, p, 0);
    pb = last_res;
    run_op(pa, xb, p, 0);
    sa = last_res;
    run_op(pb, xa, p, 0);
    sb = last_res;
    chk("dh_shared_match", sa, sb);
    for (int i = 0; i < 6; i++) run_op($urandom, $urandom, $urandom_range(0, 3) == 0 ? $urandom_range(0, 40) : $urandom, 0);
    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
